wfifo_ingress: RTL and testbench



---
 rtl/fifo_pkg.sv | 18 +
 rtl/wfifo_ingress.sv | 111 +++++++++++
 tb/tb_wfifo_ingress.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_pkg
//  Description : Shared types for the async FIFO ingress/egress stages.
//                Holds the skid-buffer occupancy state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

   // Skid-buffer occupancy: no word, head only, head plus skid.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } ingress_state_e;

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/wfifo_ingress.sv
`default_nettype none
// ============================================================================
//  Module      : wfifo_ingress
//  Description : Write-side ingress stage of the async FIFO. A 2-entry skid
//                buffer absorbs the one-cycle lag of the registered full flag,
//                drives the write request/data into the FIFO and counts the
//                words committed since reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module wfifo_ingress
   import fifo_pkg::*;
#(
   parameter int DATASIZE = 8,
   parameter int CNTSIZE  = 16
) (
   input  logic                wclk,
   input  logic                wrst,
   input  logic                s_valid,
   output logic                s_ready,
   input  logic [DATASIZE-1:0] s_data,
   input  logic                wfull,
   output logic                winc,
   output logic [DATASIZE-1:0] wdata,
   output logic [CNTSIZE-1:0]  wcount
);

   ingress_state_e      state_q, state_d;
   logic [DATASIZE-1:0] head_q,  head_d;
   logic [DATASIZE-1:0] skid_q,  skid_d;
   logic [CNTSIZE-1:0]  cnt_q,   cnt_d;

   logic accept;
   logic commit;

   // Ready is decoded from the state flop alone, so wfull/s_valid never
   // reach s_ready combinationally.
   assign s_ready = ~wrst & (state_q != TWO);
   assign accept  = s_valid & s_ready;
   // Same ~wfull gating as the pointer logic: every winc is a real write.
   assign commit  = (state_q != EMPTY) & ~wfull;

   assign winc   = commit;
   assign wdata  = head_q;
   assign wcount = cnt_q;

   // Next-state and skid-buffer data steering.
   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      skid_d  = skid_q;
      case (state_q)
         EMPTY: begin
            if (accept) begin
               state_d = ONE;
               head_d  = s_data;
            end
         end
         ONE: begin
            if (accept && commit) begin
               head_d = s_data;
            end else if (accept) begin
               state_d = TWO;
               skid_d  = s_data;
            end else if (commit) begin
               state_d = EMPTY;
            end
         end
         TWO: begin
            if (commit) begin
               state_d = ONE;
               head_d  = skid_q;
            end
         end
         default: begin
            state_d = EMPTY;
         end
      endcase
   end

   // State, head and skid registers; reset drops any buffered words.
   always_ff @(posedge wclk) begin
      if (wrst) begin
         state_q <= EMPTY;
         head_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         skid_q  <= skid_d;
      end
   end

   // Committed-word count next value, wrapping naturally at 2^CNTSIZE.
   always_comb begin
      cnt_d = cnt_q;
      if (commit) begin
         cnt_d = cnt_q + CNTSIZE'(1);
      end
   end

   // Committed-word counter register.
   always_ff @(posedge wclk) begin
      if (wrst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule : wfifo_ingress
`default_nettype wire

// File: tb/tb_wfifo_ingress.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wfifo_ingress
//  Description : Bench for wfifo_ingress paired with a depth-16 write-pointer
//                / full-flag model and a bench-controlled reader.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wfifo_ingress;

   localparam int DATASIZE = 8;
   localparam int CNTSIZE  = 16;
   localparam int DEPTH    = 16;

   logic                wclk = 1'b0;
   logic                wrst;
   logic                s_valid;
   logic                s_ready;
   logic [DATASIZE-1:0] s_data;
   logic                wfull;
   logic                winc;
   logic [DATASIZE-1:0] wdata;
   logic [CNTSIZE-1:0]  wcount;
   logic                rd_en;

   int checks = 0;
   int errors = 0;

   logic [DATASIZE-1:0] exp_q[$];

   int occ;
   bit w_do, r_do;

   wfifo_ingress #(.DATASIZE(DATASIZE), .CNTSIZE(CNTSIZE)) dut (
      .wclk    (wclk),
      .wrst    (wrst),
      .s_valid (s_valid),
      .s_ready (s_ready),
      .s_data  (s_data),
      .wfull   (wfull),
      .winc    (winc),
      .wdata   (wdata),
      .wcount  (wcount)
   );

   always #5 wclk = ~wclk;

   // Downstream pointer/full model: occupancy of a 16-deep FIFO with a
   // registered full flag that rises one cycle after the filling write.
   always @(negedge wclk) begin
      w_do = winc && !wrst;
      r_do = rd_en && (occ > 0);
   end

   always @(posedge wclk) begin
      if (wrst) begin
         occ   <= 0;
         wfull <= 1'b0;
      end else begin
         occ   <= occ + int'(w_do) - int'(r_do);
         wfull <= ((occ + int'(w_do) - int'(r_do)) == DEPTH);
      end
   end

   // Scoreboard input: every accepted word is expected to be committed in order.
   always @(negedge wclk) begin
      if (wrst) begin
         exp_q.delete();
      end else if (s_valid && s_ready) begin
         exp_q.push_back(s_data);
      end
   end

   // Monitor: every commit must present the oldest outstanding accepted word.
   always @(negedge wclk) begin
      logic [DATASIZE-1:0] e;
      if (!wrst && winc) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL mon_wdata actual=%0h required=<no outstanding word>", wdata);
         end else begin
            e = exp_q.pop_front();
            if (wdata !== e) begin
               errors++;
               $display("FAIL mon_wdata actual=%0h required=%0h", wdata, e);
            end
         end
      end
   end

   // Global watchdog.
   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   // Offer one word and hold it until accepted; called at posedge+1.
   task automatic send(input logic [7:0] d);
      bit done = 1'b0;
      s_valid = 1'b1;
      s_data  = d;
      for (int n = 0; n < 50 && !done; n++) begin
         @(negedge wclk);
         if (s_ready) done = 1'b1;
         @(posedge wclk); #1;
      end
      s_valid = 1'b0;
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL send_accept actual=not_accepted required=accepted word=%0h", d);
      end
   endtask

   // Reader pops one word; returns at posedge+1 just after the pop edge.
   task automatic pop_one();
      rd_en = 1'b1;
      @(posedge wclk); #1;
      rd_en = 1'b0;
   endtask

   initial begin
      int  sent;
      int  cyc;
      bit  acc;

      wrst    = 1'b1;
      s_valid = 1'b1;
      s_data  = 8'h01;
      rd_en   = 1'b0;

      // ---- 1. reset with s_valid held high ----
      @(posedge wclk); #1;
      for (int k = 0; k < 3; k++) begin
         @(negedge wclk);
         chk("rst_s_ready", 32'(s_ready), 32'd0);
         chk("rst_winc",    32'(winc),    32'd0);
         chk("rst_wcount",  32'(wcount),  32'd0);
         @(posedge wclk); #1;
      end
      wrst = 1'b0;
      @(negedge wclk);
      chk("rel_s_ready", 32'(s_ready), 32'd1);
      @(posedge wclk); #1;
      s_valid = 1'b0;
      @(negedge wclk);
      chk("first_winc",  32'(winc),  32'd1);
      chk("first_wdata", 32'(wdata), 32'h01);
      @(posedge wclk); #1;

      // fresh start for the fill sequence
      wrst = 1'b1;
      @(posedge wclk); #1;
      wrst = 1'b0;

      // ---- 2. stream 16 words into the empty FIFO ----
      for (int i = 0; i < 16; i++) send(8'(i));

      // ---- 3. two more words land in the skid buffer behind wfull ----
      send(8'h10);
      send(8'h11);
      chk("skid_pending", 32'(exp_q.size()), 32'd2);
      for (int k = 0; k < 3; k++) begin
         @(negedge wclk);
         chk("full_s_ready", 32'(s_ready), 32'd0);
         chk("full_winc",    32'(winc),    32'd0);
         chk("full_wfull",   32'(wfull),   32'd1);
         chk("full_wcount",  32'(wcount),  32'd16);
         @(posedge wclk); #1;
      end

      // ---- 4. release: one pop per committed word ----
      pop_one();
      @(negedge wclk);
      chk("rel1_winc",    32'(winc),    32'd1);
      chk("rel1_wdata",   32'(wdata),   32'h10);
      chk("rel1_s_ready", 32'(s_ready), 32'd0);
      @(posedge wclk); #1;
      @(negedge wclk);
      chk("rel1b_s_ready", 32'(s_ready), 32'd1);
      chk("rel1b_winc",    32'(winc),    32'd0);
      chk("rel1b_wcount",  32'(wcount),  32'd17);
      @(posedge wclk); #1;
      pop_one();
      @(negedge wclk);
      chk("rel2_winc",    32'(winc),    32'd1);
      chk("rel2_wdata",   32'(wdata),   32'h11);
      chk("rel2_s_ready", 32'(s_ready), 32'd1);
      @(posedge wclk); #1;
      @(negedge wclk);
      chk("rel2b_wcount", 32'(wcount), 32'd18);
      chk("rel2b_winc",   32'(winc),   32'd0);
      @(posedge wclk); #1;

      // ---- 6. mid-operation reset while TWO (skid = 0x22) ----
      send(8'h21);
      send(8'h22);
      @(negedge wclk);
      chk("two_s_ready", 32'(s_ready), 32'd0);
      chk("two_winc",    32'(winc),    32'd0);
      @(posedge wclk); #1;
      wrst = 1'b1;
      @(posedge wclk); #1;
      wrst = 1'b0;
      @(negedge wclk);
      chk("mrst_wcount",  32'(wcount),  32'd0);
      chk("mrst_winc",    32'(winc),    32'd0);
      chk("mrst_s_ready", 32'(s_ready), 32'd1);
      @(posedge wclk); #1;
      rd_en = 1'b1;
      repeat (5) begin @(posedge wclk); #1; end
      @(negedge wclk);
      chk("mrst_idle_winc",   32'(winc),   32'd0);
      chk("mrst_idle_wcount", 32'(wcount), 32'd0);
      @(posedge wclk); #1;

      // ---- 5. 1000 words with upstream gaps and reader stalls ----
      sent    = 0;
      cyc     = 0;
      s_valid = 1'b0;
      while (sent < 1000 && cyc < 20000) begin
         if (!s_valid) begin
            s_valid = ($urandom_range(0, 3) != 0);
            s_data  = 8'($urandom);
         end
         rd_en = 1'($urandom_range(0, 1));
         @(negedge wclk);
         acc = s_valid && s_ready;
         @(posedge wclk); #1;
         if (acc) begin
            sent++;
            s_valid = 1'b0;
         end
         cyc++;
      end
      s_valid = 1'b0;
      chk("rand_sent", 32'(sent), 32'd1000);
      rd_en = 1'b1;
      for (int n = 0; n < 200 && exp_q.size() != 0; n++) begin
         @(posedge wclk); #1;
      end
      chk("rand_drained", 32'(exp_q.size()), 32'd0);
      @(negedge wclk);
      chk("rand_wcount", 32'(wcount), 32'd1000);
      chk("rand_winc",   32'(winc),   32'd0);
      @(posedge wclk); #1;
      rd_en = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_wfifo_ingress
`default_nettype wire
